icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/cpu_types_pkg.sv | 21 ++
 rtl/icache_if.sv | 25 ++
 rtl/icache.sv | 103 ++++++++++
 tb/tb_icache.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction word, icache address decode and FSM state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Default geometry: 16 frames of one word each.
  localparam int IIDX_W = 4;
  localparam int ITAG_W = 32 - IIDX_W - 2;

  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [1:0]        bytoff;
  } icachef_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// Fetch-stage and memory-controller signals of the instruction cache.
interface icache_if;
  import cpu_types_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;

  // Environment side: pipeline fetch stage plus memory controller.
  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );

  // Cache side.
  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with a single
// outstanding fill. Hits return data in the same cycle.
module icache
  import cpu_types_pkg::*;
#(
  parameter int SETS = 16
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;

  icache_state_t state_q, state_d;
  word_t         miss_q, miss_d;

  logic [SETS-1:0] valid_q;
  logic [TW-1:0]   tag_q  [SETS];
  word_t           data_q [SETS];

  // Request decode; byte offset is irrelevant for a word-wide fetch.
  logic [IW-1:0] req_idx;
  logic [TW-1:0] req_tag;
  icachef_t      unused_req_f;
  assign req_idx      = imemaddr[IW+1:2];
  assign req_tag      = imemaddr[31:IW+2];
  assign unused_req_f = imemaddr;

  logic [IW-1:0] miss_idx;
  logic [TW-1:0] miss_tag;
  assign miss_idx = miss_q[IW+1:2];
  assign miss_tag = miss_q[31:IW+2];

  logic lookup_hit, fill;
  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  // Reset wins over a completing fill.
  assign fill       = (state_q == FETCH) && !iwait && !RST;

  // State, miss address and valid bits: the only state needing reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      miss_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
      if (fill) valid_q[miss_idx] <= 1'b1;
    end
  end

  // Tag and data arrays are only meaningful under a set valid bit.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= iload;
    end
  end

  // Next state; the miss address is captured once and held through FETCH
  // so a redirect of imemaddr cannot corrupt the outstanding fill.
  always_comb begin
    state_d = state_q;
    miss_d  = miss_q;
    case (state_q)
      IDLE: if (imemREN && !lookup_hit) begin
        state_d = FETCH;
        miss_d  = {imemaddr[31:2], 2'b00};
      end
      FETCH: if (!iwait) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: hit path only in IDLE, memory request only in FETCH.
  always_comb begin
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = '0;
    case (state_q)
      IDLE: if (imemREN && lookup_hit) begin
        ihit     = 1'b1;
        imemload = data_q[req_idx];
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = miss_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized
// requests against a frame-level reference model.
module tb_icache;
  import cpu_types_pkg::*;

  localparam int SETS = 16;

  logic CLK, RST;
  icache_if bus ();

  icache #(.SETS(SETS)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .imemREN  (bus.imemREN),
    .imemaddr (bus.imemaddr),
    .ihit     (bus.ihit),
    .imemload (bus.imemload),
    .iREN     (bus.iREN),
    .iaddr    (bus.iaddr),
    .iwait    (bus.iwait),
    .iload    (bus.iload)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: which word address each frame holds, and its data.
  bit          mv [SETS];
  logic [29:0] mw [SETS];
  word_t       md [SETS];

  function automatic int frame_of(input word_t a);
    return int'((a >> 2) % SETS);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < SETS; i++) mv[i] = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One fetch through the cache: checks the lookup cycle and, on a miss,
  // every FETCH cycle of a fill that waits 'waits' cycles then returns d.
  task automatic req(input word_t a, input int waits, input word_t d,
                     input string nm);
    bit    exp_hit;
    word_t exp_load;
    int    f;
    f           = frame_of(a);
    bus.imemREN = 1'b1;
    bus.imemaddr = a;
    bus.iwait   = 1'b1;
    @(negedge CLK);
    exp_hit  = mv[f] && (mw[f] == a[31:2]);
    exp_load = exp_hit ? md[f] : 32'h0;
    n_checks++;
    if (bus.ihit !== exp_hit || bus.imemload !== exp_load ||
        bus.iREN !== 1'b0 || bus.iaddr !== 32'h0)
      $display("FAIL %s lookup a=%h: ihit=%b load=%h iREN=%b iaddr=%h want ihit=%b load=%h iREN=0 iaddr=0",
               nm, a, bus.ihit, bus.imemload, bus.iREN, bus.iaddr, exp_hit, exp_load);
    else n_pass++;
    step();
    if (!exp_hit) begin
      for (int i = 0; i <= waits; i++) begin
        bus.iwait = (i < waits);
        bus.iload = (i < waits) ? 32'hDEAD_BEEF : d;
        @(negedge CLK);
        n_checks++;
        if (bus.iREN !== 1'b1 || bus.iaddr !== {a[31:2], 2'b00} ||
            bus.ihit !== 1'b0 || bus.imemload !== 32'h0)
          $display("FAIL %s fill cyc%0d a=%h: iREN=%b iaddr=%h ihit=%b load=%h want iREN=1 iaddr=%h ihit=0 load=0",
                   nm, i, a, bus.iREN, bus.iaddr, bus.ihit, bus.imemload, {a[31:2], 2'b00});
        else n_pass++;
        step();
      end
      bus.iwait = 1'b1;
      mv[f] = 1'b1;
      mw[f] = a[31:2];
      md[f] = d;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.imemREN = 1'b0; bus.imemaddr = '0; bus.iwait = 1'b1; bus.iload = '0;
    step(); step();
    @(negedge CLK);
    n_checks++;
    if (bus.ihit !== 1'b0 || bus.imemload !== 32'h0 ||
        bus.iREN !== 1'b0 || bus.iaddr !== 32'h0)
      $display("FAIL reset: ihit=%b load=%h iREN=%b iaddr=%h want all zero",
               bus.ihit, bus.imemload, bus.iREN, bus.iaddr);
    else n_pass++;
    step();
    RST = 1'b0;
    model_clear();
  endtask

  task automatic test_cold_miss();
    req(32'h0000_0040, 3, 32'h2001_0005, "cold_miss");
    req(32'h0000_0040, 0, 32'h0, "cold_miss_hit");
  endtask

  task automatic test_repeat_hit();
    req(32'h0000_0042, 0, 32'h0, "repeat_hit");
  endtask

  task automatic test_conflict();
    req(32'h0000_0080, 1, 32'hA5A5_0080, "conflict_miss");
    req(32'h0000_0080, 0, 32'h0, "conflict_hit");
    req(32'h0000_0040, 0, 32'h2001_0005, "conflict_evicted");
  endtask

  task automatic test_redirect();
    bus.imemREN = 1'b1; bus.imemaddr = 32'h0000_0100; bus.iwait = 1'b1;
    step();  // lookup misses, enter FETCH
    bus.imemaddr = 32'h0000_0200;
    for (int i = 0; i < 3; i++) begin
      bus.iwait = (i < 2);
      bus.iload = 32'h1111_0100;
      @(negedge CLK);
      n_checks++;
      if (bus.iREN !== 1'b1 || bus.iaddr !== 32'h0000_0100 || bus.ihit !== 1'b0)
        $display("FAIL redirect fill cyc%0d: iREN=%b iaddr=%h ihit=%b want 1/00000100/0",
                 i, bus.iREN, bus.iaddr, bus.ihit);
      else n_pass++;
      step();
    end
    bus.iwait = 1'b1;
    mv[frame_of(32'h100)] = 1'b1;
    mw[frame_of(32'h100)] = 30'h40;
    md[frame_of(32'h100)] = 32'h1111_0100;
    req(32'h0000_0200, 2, 32'h2222_0200, "redirect_second_miss");
    req(32'h0000_0200, 0, 32'h0, "redirect_hit");
    req(32'h0000_0104, 0, 32'h3333_0104, "redirect_neighbor");
  endtask

  task automatic test_reset_mid_fill();
    bus.imemREN = 1'b1; bus.imemaddr = 32'h0000_0300; bus.iwait = 1'b1;
    step();  // into FETCH
    bus.iwait = 1'b0; bus.iload = 32'hBAD0_0300; RST = 1'b1;
    step();
    RST = 1'b0; bus.iwait = 1'b1; bus.imemREN = 1'b0;
    model_clear();
    @(negedge CLK);
    n_checks++;
    if (bus.iREN !== 1'b0 || bus.iaddr !== 32'h0 || bus.ihit !== 1'b0)
      $display("FAIL reset_mid_fill: iREN=%b iaddr=%h ihit=%b want 0/0/0",
               bus.iREN, bus.iaddr, bus.ihit);
    else n_pass++;
    step();
    req(32'h0000_0300, 1, 32'h4444_0300, "reset_mid_fill_rereq");
  endtask

  task automatic test_idle();
    req(32'h0000_0044, 0, 32'h5555_0044, "idle_fill");
    bus.imemREN = 1'b0; bus.imemaddr = 32'h0000_0044;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      n_checks++;
      if (bus.ihit !== 1'b0 || bus.iREN !== 1'b0 || bus.imemload !== 32'h0)
        $display("FAIL idle cyc%0d: ihit=%b iREN=%b load=%h want 0/0/0",
                 i, bus.ihit, bus.iREN, bus.imemload);
      else n_pass++;
      step();
    end
    req(32'h0000_0044, 0, 32'h0, "idle_then_hit");
  endtask

  task automatic test_random();
    word_t a;
    for (int n = 0; n < 80; n++) begin
      a = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom), 2'($urandom)};
      if ($urandom_range(0, 7) == 0) a[31:28] = 4'($urandom);
      req(a, $urandom_range(0, 3), $urandom, "random");
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_repeat_hit();
    test_conflict();
    test_redirect();
    test_reset_mid_fill();
    test_idle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
